ahb_multi_arbiter: RTL and testbench

AHB_MULTI_ARBITER -- requirements
Module: ahb_multi_arbiter

---
 rtl/ahb_arb_pkg.sv | 50 +++++
 rtl/ahb_arb_picker.sv | 34 +++
 rtl/ahb_multi_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ahb_multi_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared Htrans/Hburst encodings, arbiter FSM state type and burst-length helper.
// Defining AHB_ARB_LOCK_EN adds the LOCKED state used for locked transfers.
package ahb_arb_pkg;

  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

`ifdef AHB_ARB_LOCK_EN
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_BURST_FIXED = 2'd1,
    ST_BURST_INCR  = 2'd2,
    ST_LOCKED      = 2'd3
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_BURST_FIXED = 2'd1,
    ST_BURST_INCR  = 2'd2
  } arb_state_e;
`endif

  // Remaining SEQ beats after the NONSEQ of a fixed-length burst.
  function automatic logic [CNT_W-1:0] burst_len_m1(input logic [2:0] hburst);
    logic [CNT_W-1:0] len_m1;
    len_m1 = '0;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  len_m1 = CNT_W'(3);
      HBURST_WRAP8,  HBURST_INCR8:  len_m1 = CNT_W'(7);
      HBURST_WRAP16, HBURST_INCR16: len_m1 = CNT_W'(15);
      HBURST_SINGLE, HBURST_INCR:   len_m1 = '0;
      default:                      len_m1 = '0;
    endcase
    return len_m1;
  endfunction

endpackage

// File: rtl/ahb_arb_picker.sv
// Winner selection: round-robin from last owner + 1 (owner last), or lowest index first.
module ahb_arb_picker #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned PRIO_MODE   = 0
) (
  input  logic [NUM_MASTERS-1:0]         i_req,
  input  logic [$clog2(NUM_MASTERS)-1:0] i_last,
  output logic [$clog2(NUM_MASTERS)-1:0] o_winner_c
);

  localparam int unsigned IW = $clog2(NUM_MASTERS);

  logic [IW-1:0] w_idx;
  logic          w_found;

  // Candidate order never produces an index >= NUM_MASTERS.
  always_comb begin
    o_winner_c = i_last;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (PRIO_MODE == 32'd1) begin
        w_idx = IW'(i);
      end else begin
        w_idx = IW'((32'(i_last) + i + 32'd1) % NUM_MASTERS);
      end
      if (!w_found && i_req[w_idx]) begin
        o_winner_c = w_idx;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_multi_arbiter.sv
// AHB bus arbiter: tracks bursts of the address-phase owner and moves the grant at handover points.
// Defining AHB_ARB_LOCK_EN enables locked transfers (LOCKED state, Hmastlock).
module ahb_multi_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned PRIO_MODE      = 0
) (
  input  logic                           Hclk,
  input  logic                           Hresetn,
  input  logic [NUM_MASTERS-1:0]         Hreq,
  input  logic [NUM_MASTERS-1:0]         Hlock,
  input  logic                           Hready,
  input  logic [1:0]                     Htrans,
  input  logic [2:0]                     Hburst,
  output logic [NUM_MASTERS-1:0]         Hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] Hmaster,
  output logic                           Hmastlock
);

  localparam int unsigned IW  = $clog2(NUM_MASTERS);
  localparam int unsigned DEF = DEFAULT_MASTER % NUM_MASTERS;

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  logic [IW-1:0]          r_grant_idx;
  logic [IW-1:0]          w_grant_idx_nxt;
  logic [IW-1:0]          r_master;
  logic [IW-1:0]          w_pick;
  logic [IW-1:0]          w_winner;
  logic                   w_handover;

  ahb_arb_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .PRIO_MODE   (PRIO_MODE)
  ) u_picker (
    .i_req      (Hreq),
    .i_last     (r_grant_idx),
    .o_winner_c (w_pick)
  );

  assign w_winner = (Hreq == '0) ? IW'(DEF) : w_pick;

  // State register: frozen while the current transfer is wait-stated.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (Hready) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: follow the owner's Htrans/Hburst.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (Hready) begin
`ifdef AHB_ARB_LOCK_EN
      if (r_state == ST_LOCKED) begin
        if (!Hlock[r_master] && Htrans == HTRANS_IDLE) begin
          w_state_nxt = ST_IDLE;
        end
      end else if (Htrans == HTRANS_NONSEQ && Hlock[r_master]) begin
        w_state_nxt = ST_LOCKED;
        w_cnt_nxt   = '0;
      end else
`endif
      begin
        case (Htrans)
          HTRANS_NONSEQ: begin
            w_cnt_nxt = burst_len_m1(Hburst);
            if (Hburst == HBURST_SINGLE) begin
              w_state_nxt = ST_IDLE;
            end else if (Hburst == HBURST_INCR) begin
              w_state_nxt = ST_BURST_INCR;
            end else begin
              w_state_nxt = ST_BURST_FIXED;
            end
          end
          HTRANS_SEQ: begin
            if (r_state == ST_BURST_FIXED) begin
              if (r_cnt <= CNT_W'(1)) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
              end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
              end
            end
          end
          HTRANS_IDLE: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
          HTRANS_BUSY: ;
          default: ;
        endcase
      end
    end
  end

  // Handover whenever the FSM lands in IDLE (a burst just starting keeps its
  // grant), or when an undefined-length owner drops its request.
  always_comb begin
    w_handover      = 1'b0;
    w_grant_idx_nxt = r_grant_idx;
    if (Hready) begin
      if (w_state_nxt == ST_IDLE) begin
        w_handover = 1'b1;
      end else if (r_state == ST_BURST_INCR && w_state_nxt == ST_BURST_INCR &&
                   !Hreq[r_master]) begin
        w_handover = 1'b1;
      end
    end
    if (w_handover) begin
      w_grant_idx_nxt = w_winner;
    end
    w_grant_nxt = NUM_MASTERS'(1) << w_grant_idx_nxt;
  end

  // Hmaster follows the grant one completed transfer later.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_grant     <= NUM_MASTERS'(1) << DEF;
      r_grant_idx <= IW'(DEF);
      r_master    <= IW'(DEF);
    end else if (Hready) begin
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_master    <= r_grant_idx;
    end
  end

  assign Hgrant  = r_grant;
  assign Hmaster = r_master;

`ifdef AHB_ARB_LOCK_EN
  logic r_mastlock;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_mastlock <= 1'b0;
    end else if (Hready) begin
      r_mastlock <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign Hmastlock = r_mastlock;
`else
  logic w_unused_lock;

  assign w_unused_lock = ^Hlock;
  assign Hmastlock     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_multi_arbiter.sv
// Directed bench for ahb_multi_arbiter: round-robin, fixed-priority and 3-master instances.
module tb_ahb_multi_arbiter;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;
  localparam logic [2:0] B_INCR16 = 3'b111;

  logic       Hclk    = 1'b0;
  logic       Hresetn = 1'b1;
  logic [3:0] Hreq    = '0;
  logic [3:0] Hlock   = '0;
  logic [2:0] Hreq3   = '0;
  logic       Hready  = 1'b1;
  logic [1:0] Htrans  = T_IDLE;
  logic [2:0] Hburst  = B_SINGLE;

  logic [3:0] g_rr, g_fp;
  logic [1:0] m_rr, m_fp;
  logic       l_rr, l_fp;
  logic [2:0] g_n3;
  logic [1:0] m_n3;
  logic       l_n3;

  int checks   = 0;
  int failures = 0;

  always #5 Hclk = ~Hclk;

  ahb_multi_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .PRIO_MODE(0)) u_rr (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hreq(Hreq), .Hlock(Hlock), .Hready(Hready),
    .Htrans(Htrans), .Hburst(Hburst), .Hgrant(g_rr), .Hmaster(m_rr), .Hmastlock(l_rr));

  ahb_multi_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(2), .PRIO_MODE(1)) u_fp (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hreq(Hreq), .Hlock(Hlock), .Hready(Hready),
    .Htrans(Htrans), .Hburst(Hburst), .Hgrant(g_fp), .Hmaster(m_fp), .Hmastlock(l_fp));

  ahb_multi_arbiter #(.NUM_MASTERS(3), .DEFAULT_MASTER(0), .PRIO_MODE(0)) u_n3 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hreq(Hreq3), .Hlock(Hlock[2:0]), .Hready(Hready),
    .Htrans(Htrans), .Hburst(Hburst), .Hgrant(g_n3), .Hmaster(m_n3), .Hmastlock(l_n3));

  task automatic cyc();
    @(posedge Hclk);
    #1;
  endtask

  // Park the round-robin grant and Hmaster on one master.
  task automatic own(input int idx);
    Htrans = T_IDLE;
    Hreq   = 4'(1 << idx);
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    Hready = 1'b1;
    #2 Hresetn = 1'b0;
    #1;
    checks++; if (g_rr !== 4'b0001) begin failures++; $display("FAIL rst_grant_rr got=%b exp=0001", g_rr); end
    checks++; if (m_rr !== 2'd0) begin failures++; $display("FAIL rst_master_rr got=%0d exp=0", m_rr); end
    checks++; if (l_rr !== 1'b0) begin failures++; $display("FAIL rst_lock_rr got=%b exp=0", l_rr); end
    checks++; if (g_fp !== 4'b0100) begin failures++; $display("FAIL rst_grant_fp got=%b exp=0100", g_fp); end
    checks++; if (m_fp !== 2'd2) begin failures++; $display("FAIL rst_master_fp got=%0d exp=2", m_fp); end
    checks++; if (l_fp !== 1'b0) begin failures++; $display("FAIL rst_lock_fp got=%b exp=0", l_fp); end
    checks++; if (g_n3 !== 3'b001 || l_n3 !== 1'b0) begin failures++; $display("FAIL rst_n3 got=%b/%b exp=001/0", g_n3, l_n3); end
    @(negedge Hclk);
    Hresetn = 1'b1;
    cyc();
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [6];
    logic [1:0] em [6];
    logic [2:0] eg3 [4];
    logic [1:0] em3 [4];
    eg  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    em  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    eg3 = '{3'b010, 3'b100, 3'b001, 3'b010};
    em3 = '{2'd0, 2'd1, 2'd2, 2'd0};
    Hreq = 4'b1111; Hreq3 = 3'b111; Htrans = T_NONSEQ; Hburst = B_SINGLE;
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++; if (g_rr !== eg[k]) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, g_rr, eg[k]); end
      checks++; if (m_rr !== em[k]) begin failures++; $display("FAIL rr_master[%0d] got=%0d exp=%0d", k, m_rr, em[k]); end
      if (k < 4) begin
        checks++; if (g_n3 !== eg3[k] || m_n3 !== em3[k]) begin failures++; $display("FAIL rr3[%0d] got=%b/%0d exp=%b/%0d", k, g_n3, m_n3, eg3[k], em3[k]); end
      end
    end
    Hreq3 = '0; Hreq = '0; Htrans = T_IDLE;
    cyc();
  endtask

  task automatic test_fixed_burst();
    logic [3:0] exp_g;
    own(2);
    Hreq = 4'b0101; Htrans = T_NONSEQ; Hburst = B_INCR8;
    cyc();
    checks++; if (g_rr !== 4'b0100) begin failures++; $display("FAIL fb_beat1 got=%b exp=0100", g_rr); end
    Htrans = T_SEQ;
    for (int b = 2; b <= 8; b++) begin
      cyc();
      exp_g = (b == 8) ? 4'b0001 : 4'b0100;
      checks++; if (g_rr !== exp_g) begin failures++; $display("FAIL fb_beat%0d got=%b exp=%b", b, g_rr, exp_g); end
      checks++; if (m_rr !== 2'd2) begin failures++; $display("FAIL fb_master%0d got=%0d exp=2", b, m_rr); end
    end
    Htrans = T_IDLE; Hreq = '0;
    cyc();
  endtask

  task automatic test_wait_states();
    own(1);
    Hreq = 4'b0011; Htrans = T_NONSEQ; Hburst = B_INCR4;
    cyc();
    checks++; if (g_rr !== 4'b0010) begin failures++; $display("FAIL ws_beat1 got=%b exp=0010", g_rr); end
    Htrans = T_SEQ; Hready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      cyc();
      checks++; if (g_rr !== 4'b0010 || m_rr !== 2'd1) begin failures++; $display("FAIL ws_wait%0d got=%b/%0d exp=0010/1", w, g_rr, m_rr); end
    end
    Hready = 1'b1;
    cyc();
    checks++; if (g_rr !== 4'b0010) begin failures++; $display("FAIL ws_beat2 got=%b exp=0010", g_rr); end
    Htrans = T_BUSY;
    cyc();
    checks++; if (g_rr !== 4'b0010) begin failures++; $display("FAIL ws_busy got=%b exp=0010", g_rr); end
    Htrans = T_SEQ;
    cyc();
    checks++; if (g_rr !== 4'b0010) begin failures++; $display("FAIL ws_beat3 got=%b exp=0010", g_rr); end
    cyc();
    checks++; if (g_rr !== 4'b0001) begin failures++; $display("FAIL ws_beat4 got=%b exp=0001", g_rr); end
    Htrans = T_IDLE; Hreq = '0;
    cyc();
  endtask

  task automatic test_early_term();
    own(3);
    Hreq = 4'b1100; Htrans = T_NONSEQ; Hburst = B_INCR8;
    cyc();
    Htrans = T_SEQ;
    cyc();
    cyc();
    checks++; if (g_rr !== 4'b1000) begin failures++; $display("FAIL et_beat3 got=%b exp=1000", g_rr); end
    Htrans = T_IDLE;
    cyc();
    checks++; if (g_rr !== 4'b0100) begin failures++; $display("FAIL et_handover got=%b exp=0100", g_rr); end
    checks++; if (m_rr !== 2'd3) begin failures++; $display("FAIL et_master got=%0d exp=3", m_rr); end
    Hreq = '0;
    cyc();
  endtask

  task automatic test_incr_reload();
    own(1);
    Hreq = 4'b0011; Htrans = T_NONSEQ; Hburst = B_INCR;
    cyc();
    checks++; if (g_rr !== 4'b0010) begin failures++; $display("FAIL incr_start got=%b exp=0010", g_rr); end
    Htrans = T_SEQ;
    cyc();
    checks++; if (g_rr !== 4'b0010) begin failures++; $display("FAIL incr_hold got=%b exp=0010", g_rr); end
    Hreq = 4'b0001;
    cyc();
    checks++; if (g_rr !== 4'b0001) begin failures++; $display("FAIL incr_drop got=%b exp=0001", g_rr); end
    own(1);
    Hreq = 4'b0011; Htrans = T_NONSEQ; Hburst = B_INCR4;
    cyc();
    Htrans = T_SEQ;
    cyc();
    Htrans = T_NONSEQ;
    cyc();
    checks++; if (g_rr !== 4'b0010) begin failures++; $display("FAIL rl_nonseq got=%b exp=0010", g_rr); end
    Htrans = T_SEQ;
    cyc();
    cyc();
    checks++; if (g_rr !== 4'b0010) begin failures++; $display("FAIL rl_seq2 got=%b exp=0010", g_rr); end
    cyc();
    checks++; if (g_rr !== 4'b0001) begin failures++; $display("FAIL rl_last got=%b exp=0001", g_rr); end
    Htrans = T_IDLE; Hreq = '0;
    cyc();
  endtask

  task automatic test_parking();
    Hreq = '0; Htrans = T_IDLE;
    cyc();
    cyc();
    checks++; if (g_rr !== 4'b0001 || m_rr !== 2'd0) begin failures++; $display("FAIL park_rr got=%b/%0d exp=0001/0", g_rr, m_rr); end
    checks++; if (g_fp !== 4'b0100 || m_fp !== 2'd2) begin failures++; $display("FAIL park_fp got=%b/%0d exp=0100/2", g_fp, m_fp); end
    Hready = 1'b0; Hreq = 4'b1010;
    cyc();
    cyc();
    checks++; if (g_rr !== 4'b0001 || g_fp !== 4'b0100) begin failures++; $display("FAIL park_wait got=%b/%b exp=0001/0100", g_rr, g_fp); end
    Hready = 1'b1; Htrans = T_NONSEQ; Hburst = B_SINGLE;
    cyc();
    checks++; if (g_fp !== 4'b0010) begin failures++; $display("FAIL fp_win1 got=%b exp=0010", g_fp); end
    checks++; if (g_rr !== 4'b0010) begin failures++; $display("FAIL rr_1010_a got=%b exp=0010", g_rr); end
    cyc();
    checks++; if (g_fp !== 4'b0010 || m_fp !== 2'd1) begin failures++; $display("FAIL fp_win2 got=%b/%0d exp=0010/1", g_fp, m_fp); end
    checks++; if (g_rr !== 4'b1000) begin failures++; $display("FAIL rr_1010_b got=%b exp=1000", g_rr); end
    cyc();
    checks++; if (g_fp !== 4'b0010) begin failures++; $display("FAIL fp_win3 got=%b exp=0010", g_fp); end
    Htrans = T_IDLE; Hreq = '0;
    cyc();
  endtask

  task automatic test_lock();
    own(3);
`ifdef AHB_ARB_LOCK_EN
    Hreq = 4'b1111; Hlock = 4'b1000; Htrans = T_NONSEQ; Hburst = B_INCR4;
    cyc();
    checks++; if (g_rr !== 4'b1000 || l_rr !== 1'b1) begin failures++; $display("FAIL lk_enter got=%b/%b exp=1000/1", g_rr, l_rr); end
    Htrans = T_SEQ;
    cyc();
    Htrans = T_IDLE;
    cyc();
    checks++; if (g_rr !== 4'b1000 || l_rr !== 1'b1) begin failures++; $display("FAIL lk_idle got=%b/%b exp=1000/1", g_rr, l_rr); end
    Htrans = T_NONSEQ; Hburst = B_SINGLE;
    cyc();
    checks++; if (g_rr !== 4'b1000 || l_rr !== 1'b1) begin failures++; $display("FAIL lk_single got=%b/%b exp=1000/1", g_rr, l_rr); end
    Hlock = '0; Htrans = T_IDLE;
    cyc();
    checks++; if (g_rr !== 4'b0001 || l_rr !== 1'b0) begin failures++; $display("FAIL lk_release got=%b/%b exp=0001/0", g_rr, l_rr); end
`else
    Hreq = 4'b1111; Hlock = 4'b1111; Htrans = T_NONSEQ; Hburst = B_SINGLE;
    cyc();
    checks++; if (g_rr !== 4'b0001 || l_rr !== 1'b0) begin failures++; $display("FAIL nolk_a got=%b/%b exp=0001/0", g_rr, l_rr); end
    cyc();
    checks++; if (g_rr !== 4'b0010 || l_rr !== 1'b0) begin failures++; $display("FAIL nolk_b got=%b/%b exp=0010/0", g_rr, l_rr); end
`endif
    Hlock = '0; Htrans = T_IDLE; Hreq = '0;
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    own(2);
    Hreq = 4'b0101; Htrans = T_NONSEQ; Hburst = B_INCR16;
    cyc();
    Htrans = T_SEQ;
    cyc();
    cyc();
    cyc();
    checks++; if (g_rr !== 4'b0100) begin failures++; $display("FAIL mr_pre got=%b exp=0100", g_rr); end
    #2 Hresetn = 1'b0;
    #1;
    checks++; if (g_rr !== 4'b0001 || m_rr !== 2'd0 || l_rr !== 1'b0) begin failures++; $display("FAIL mr_async_rr got=%b/%0d/%b exp=0001/0/0", g_rr, m_rr, l_rr); end
    checks++; if (g_fp !== 4'b0100 || m_fp !== 2'd2) begin failures++; $display("FAIL mr_async_fp got=%b/%0d exp=0100/2", g_fp, m_fp); end
    @(negedge Hclk);
    Hresetn = 1'b1;
    cyc();
    checks++; if (g_rr !== 4'b0100) begin failures++; $display("FAIL mr_after got=%b exp=0100", g_rr); end
    Htrans = T_IDLE; Hreq = '0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_burst();
    test_wait_states();
    test_early_term();
    test_incr_reload();
    test_parking();
    test_lock();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
